// File: rtl/twisted_ring_counter.sv
// Parametrised Johnson/ring counter with runtime mode and direction, parallel load,
// illegal-state self-correction, a saturating correction counter, sequence index and wrap pulse.
module twisted_ring_counter #(
  parameter  int WIDTH = 4,
  localparam int IDXW  = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [IDXW-1:0]  state_idx,
  output logic             wrap,
  output logic             illegal,
  output logic [7:0]       err_cnt
);

  localparam logic [WIDTH-1:0] HOME_RING = {1'b1, {(WIDTH-1){1'b0}}};

  // Johnson codes have at most one adjacent-bit transition; ring codes are one-hot.
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
    int ones;
    int edges;
    ones  = 0;
    edges = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) ones++;
    end
    for (int i = 0; i < WIDTH-1; i++) begin
      if (v[i] != v[i+1]) edges++;
    end
    return m ? (ones == 1) : (edges <= 1);
  endfunction

  function automatic logic [IDXW-1:0] seq_idx(input logic [WIDTH-1:0] v, input logic m);
    int ones;
    int pos;
    ones = 0;
    pos  = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        ones++;
        pos = WIDTH - 1 - i;
      end
    end
    if (!is_legal(v, m)) return '0;
    if (m) return IDXW'(pos);
    // Fill phase (MSB set, or all zeros) counts ones; drain phase counts back from 2*WIDTH.
    if (v[WIDTH-1] || (v == '0)) return IDXW'(ones);
    return IDXW'(2*WIDTH - ones);
  endfunction

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic [7:0]       err_nxt;

  assign illegal   = !is_legal(count, mode);
  assign state_idx = seq_idx(count, mode);

  always_comb begin
    shifted = count;
    case ({mode, dir})
      2'b00:   shifted = {~count[0], count[WIDTH-1:1]};
      2'b01:   shifted = {count[WIDTH-2:0], ~count[WIDTH-1]};
      2'b10:   shifted = {count[0], count[WIDTH-1:1]};
      default: shifted = {count[WIDTH-2:0], count[WIDTH-1]};
    endcase
  end

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    err_nxt   = err_cnt;
    if (load) begin
      count_nxt = load_val;
    end else if (illegal) begin
      count_nxt = mode ? HOME_RING : '0;
      if (err_cnt != 8'hFF) err_nxt = err_cnt + 8'd1;
    end else if (en) begin
      count_nxt = shifted;
      // Forward wraps on arriving at index 0, reverse on leaving it.
      wrap_nxt  = dir ? (state_idx == '0) : (seq_idx(shifted, mode) == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      wrap    <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      count   <= count_nxt;
      wrap    <= wrap_nxt;
      err_cnt <= err_nxt;
    end
  end

endmodule

// File: doc/twisted_ring_counter.md
Name: twisted_ring_counter

Overview:
- Parametrised successor to the fixed 4-bit Johnson counter.
- Runtime-selectable Johnson or ring mode, up/down direction, count enable, and parallel load.
- Detects illegal states and self-corrects them, keeping a saturating correction count.
- Provides a decoded sequence index and a wrap pulse for timing/sequencing logic and test stimulus generation.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- IDXW, $clog2(2*WIDTH), width of state_idx; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low.
- en  input  1  shift enable.
- dir  input  1  0 = forward (shift toward LSB), 1 = reverse.
- mode  input  1  0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states).
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value written on load.
- count  output  WIDTH  registered counter state.
- state_idx  output  IDXW  combinational sequence position of count.
- wrap  output  1  registered 1-cycle sequence-boundary pulse.
- illegal  output  1  combinational; count is not a valid state for the current mode.
- err_cnt  output  8  registered, saturating count of auto-corrections.

Behaviour:
- Reset is synchronous, active-low, and all state updates happen on the posedge of clk.
- rst=0 at an edge sets count=0, wrap=0, err_cnt=0, regardless of any other input.
- Priority at each edge: rst > load > correction > shift > hold.
- Load: count <= load_val; loaded as-is even if illegal; wrap=0; err_cnt unchanged.
- Legality, Johnson: count has at most one adjacent-bit transition (e.g. 0000, 1100, 0111).
- Legality, ring: exactly one bit set.
- Correction: if load=0 and illegal=1, count <= home state, independent of en. err_cnt increments, saturating at 255. wrap=0.
- Home state: Johnson = all zeros; ring = MSB only set (1000 for WIDTH=4).
- Mode switch is effective immediately. If the current count is illegal in the new mode, it is corrected at the next edge (e.g. Johnson 0000 switched to ring: illegal=1, then 1000).
- Johnson forward: {~count[0], count[WIDTH-1:1]}. Johnson reverse: {count[WIDTH-2:0], ~count[WIDTH-1]}.
- Ring forward: {count[0], count[WIDTH-1:1]}. Ring reverse: {count[WIDTH-2:0], count[WIDTH-1]}.
- en=0 with no load and no correction: count holds; wrap=0.
- state_idx, Johnson: if count[WIDTH-1]=1 or count=0, state_idx = popcount(count); otherwise state_idx = 2*WIDTH - popcount(count).
- state_idx, ring: position of the set bit counted from the MSB (1000 -> 0, 0001 -> WIDTH-1).
- state_idx is 0 whenever illegal=1.
- wrap on forward shift: asserted when the new state_idx = 0.
- wrap on reverse shift: asserted when the old state_idx = 0.
- wrap is a registered pulse, so it is high in the same cycle the new count is visible.
- Latency: every update is visible one cycle after the sampling edge. No combinational path from inputs to count, wrap, or err_cnt.

Test Plan:
- WIDTH=4 Johnson forward: rst=0 for 2 cycles, then en=1, dir=0 for 9 edges -> count 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000, 1000; state_idx 0..7, 0, 1; wrap high only when count returns to 0000.
- Johnson reverse from 0000 with dir=1 -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap high with the first 0001; state_idx 7 down to 0.
- Ring mode after load_val=1000: forward -> 0100, 0010, 0001, 1000 (wrap); then dir=1 -> 0001 (wrap), 0010.
- Illegal load in Johnson mode: load 1010 with en=0 -> count=1010, illegal=1, state_idx=0; next edge count=0000, err_cnt=1. Repeat 300 times -> err_cnt saturates at 255.
- Mode switch: count=0000, mode set to 1 -> illegal=1 in the same cycle, next edge count=1000, err_cnt+1. Also load and en asserted together -> load wins.
- Mid-sequence reset: at count=1110, assert rst=0 for one edge with en=1 and load=1 -> count=0000, wrap=0, err_cnt=0; counting resumes 1000 after release. rst asserted between edges has no effect until the next edge.
